call_stack: RTL and testbench

CALL_STACK -- requirements
Module: call_stack

---
 rtl/call_stack.sv | 125 ++++++++++++
 tb/tb_call_stack.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// Purpose: LIFO return-address stack for a subroutine call/return controller.
// Latency: push/pop take effect at the rising edge; data_out is a combinational view of the top entry.
// Backpressure: none; a push while full or a pop while empty is dropped and raises a sticky flag.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   push, pop, data_in  - call (push data_in) / return (pop) requests
//   clear_flags         - synchronous clear of the sticky error flags
//   data_out            - current top of stack (zero while empty)
//   count, empty, full  - occupancy, all decoded from the count register
//   stack_overflow      - sticky: push attempted while full
//   stack_underflow     - sticky: pop attempted while empty
//
// Optional feature macro: CALL_STACK_UNDERFLOW_EN. When it is undefined the
// underflow flag is tied low and a pop on an empty stack is silently ignored.

module call_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       clear_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       stack_overflow,
  output logic                       stack_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_set;

  // Index of the top entry; only meaningful while count > 0.
  assign top_idx = AW'(count - CW'(1));

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign data_out = empty ? '0 : mem[top_idx];

`ifdef CALL_STACK_UNDERFLOW_EN
  logic unf_set;
`endif

  always_comb begin
    cnt_nxt = count;
    wr_en   = 1'b0;
    wr_idx  = count[AW-1:0];
    ovf_set = 1'b0;
`ifdef CALL_STACK_UNDERFLOW_EN
    unf_set = 1'b0;
`endif
    if (push && pop) begin
      // Call and return together replace the top entry. On an empty stack
      // there is nothing to return from, so it degenerates to a plain push.
      wr_en = 1'b1;
      if (empty) begin
        wr_idx  = '0;
        cnt_nxt = CW'(1);
      end else begin
        wr_idx  = top_idx;
      end
    end else if (push) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        cnt_nxt = count + CW'(1);
      end
    end else if (pop) begin
      if (!empty) begin
        cnt_nxt = count - CW'(1);
      end else begin
`ifdef CALL_STACK_UNDERFLOW_EN
        unf_set = 1'b1;
`endif
      end
    end
  end

  // Storage is deliberately not reset: empty forces data_out to zero, so
  // stale entries can never be observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count          <= '0;
      stack_overflow <= 1'b0;
    end else begin
      count          <= cnt_nxt;
      // A new error in the same cycle as clear_flags wins.
      stack_overflow <= ovf_set | (stack_overflow & ~clear_flags);
    end
  end

`ifdef CALL_STACK_UNDERFLOW_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stack_underflow <= 1'b0;
    end else begin
      stack_underflow <= unf_set | (stack_underflow & ~clear_flags);
    end
  end
`else
  assign stack_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
module tb_call_stack;

  localparam int DEPTH = 8;
  localparam int WIDTH = 13;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef CALL_STACK_UNDERFLOW_EN
  localparam bit UNF_EN = 1'b1;
`else
  localparam bit UNF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             push, pop, clear_flags;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             empty, full, stack_overflow, stack_underflow;

  int total = 0;
  int bad   = 0;

  call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .push            (push),
    .pop             (pop),
    .data_in         (data_in),
    .data_out        (data_out),
    .clear_flags     (clear_flags),
    .count           (count),
    .empty           (empty),
    .full            (full),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             push;
    logic             pop;
    logic             clr;
    logic [WIDTH-1:0] din;
    int               cnt;
    logic [WIDTH-1:0] dout;
    logic             emp;
    logic             ful;
    logic             ovf;
    logic             unf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic void add(input logic ps, input logic pp, input logic cl,
                              input logic [WIDTH-1:0] d, input int cnt,
                              input logic [WIDTH-1:0] dout,
                              input logic ovf, input logic unf);
    vec_t v;
    v.push = ps; v.pop = pp; v.clr = cl; v.din = d;
    v.cnt  = cnt; v.dout = dout;
    v.emp  = (cnt == 0);
    v.ful  = (cnt == DEPTH);
    v.ovf  = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare once the edge has passed.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    push = v.push; pop = v.pop; clear_flags = v.clr; data_in = v.din;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear_flags = 1'b0;
    if (exp_q.size() == 0) begin
      check($sformatf("v%0d_queue", idx), 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("v%0d_count", idx), 32'(count), 32'(e.cnt));
      check($sformatf("v%0d_dout",  idx), 32'(data_out), 32'(e.dout));
      check($sformatf("v%0d_empty", idx), 32'(empty), 32'(e.emp));
      check($sformatf("v%0d_full",  idx), 32'(full), 32'(e.ful));
      check($sformatf("v%0d_ovf",   idx), 32'(stack_overflow), 32'(e.ovf));
      check($sformatf("v%0d_unf",   idx), 32'(stack_underflow), 32'(e.unf));
    end
  endtask

  initial begin
    //   push pop clr  din      cnt dout     ovf unf
    add(1, 0, 0, 13'h0010, 1, 13'h0010, 0, 0);
    add(1, 0, 0, 13'h0020, 2, 13'h0020, 0, 0);
    add(1, 0, 0, 13'h0030, 3, 13'h0030, 0, 0);
    add(0, 1, 0, 13'h0000, 2, 13'h0020, 0, 0);
    add(1, 1, 0, 13'h0055, 2, 13'h0055, 0, 0);   // replace top
    add(0, 1, 0, 13'h0000, 1, 13'h0010, 0, 0);
    add(0, 1, 0, 13'h0000, 0, 13'h0000, 0, 0);
    add(0, 1, 0, 13'h0000, 0, 13'h0000, 0, UNF_EN);   // pop on empty
    add(0, 1, 1, 13'h0000, 0, 13'h0000, 0, UNF_EN);   // set wins over clear
    add(0, 0, 1, 13'h0000, 0, 13'h0000, 0, 0);
    add(1, 1, 0, 13'h0077, 1, 13'h0077, 0, 0);   // push+pop on empty = push
    add(0, 1, 0, 13'h0000, 0, 13'h0000, 0, 0);
    for (int i = 1; i <= DEPTH; i++)
      add(1, 0, 0, 13'(12'h100 + i), i, 13'(12'h100 + i), 0, 0);
    add(1, 0, 0, 13'h1FFF, 8, 13'h0108, 1, 0);   // overflow
    add(1, 1, 0, 13'h0ABC, 8, 13'h0ABC, 1, 0);   // replace while full
    add(0, 0, 1, 13'h0000, 8, 13'h0ABC, 0, 0);
    add(1, 0, 1, 13'h00DE, 8, 13'h0ABC, 1, 0);   // set wins over clear
    add(0, 0, 1, 13'h0000, 8, 13'h0ABC, 0, 0);
    add(0, 1, 0, 13'h0000, 7, 13'h0107, 0, 0);

    rst = 1'b0; push = 1'b0; pop = 1'b0; clear_flags = 1'b0; data_in = '0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout",  32'(data_out), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_ovf",   32'(stack_overflow), 32'd0);
    check("rst_unf",   32'(stack_underflow), 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) step(vecs[i], i);

    // Reset dropped mid-cycle while a push is being presented.
    push = 1'b1; data_in = 13'h0AAA;
    #2 rst = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_dout",  32'(data_out), 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_count", 32'(count), 32'd0);
    push = 1'b0;
    #2 rst = 1'b1;
    pop = 1'b1;
    @(posedge clk);
    #1;
    pop = 1'b0;
    check("post_rst_pop_count", 32'(count), 32'd0);
    check("post_rst_pop_unf",   32'(stack_underflow), 32'(UNF_EN));
    push = 1'b1; data_in = 13'h0123;
    @(posedge clk);
    #1;
    push = 1'b0;
    check("post_rst_push_count", 32'(count), 32'd1);
    check("post_rst_push_dout",  32'(data_out), 32'h0123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
